// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the hiddenCPU ALU: fetches 8-bit instructions over req/ack,
// drives the ALU from ACC and a 4-entry register file, and commits results, flags and PC updates.
module cpu_sequencer #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            fetch_req,
    output logic [PC_W-1:0] fetch_addr,
    input  logic [7:0]      fetch_data,
    input  logic            fetch_ack,
    input  logic [7:0]      data_in,
    output logic [7:0]      data_out,
    output logic [1:0]      alu_opcode,
    output logic [3:0]      alu_addrs,
    output logic [7:0]      alu_din0,
    output logic [7:0]      alu_din1,
    input  logic [7:0]      alu_dout,
    input  logic            alu_carry,
    input  logic            alu_borrow,
    input  logic            alu_bcf,
    input  logic            alu_bbf,
    input  logic            alu_buc,
    input  logic            alu_toggle,
    output logic [7:0]      acc_out,
    output logic            toggle_out,
    output logic            carry_flag,
    output logic            borrow_flag,
    output logic            busy,
    output logic            retire
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_acc;
    logic [7:0]      r_regs [0:2];
    logic [7:0]      r_data_out;
    logic            r_carry;
    logic            r_borrow;
    logic            r_toggle;

    logic [1:0]      w_op;
    logic [3:0]      w_a;
    logic [1:0]      w_r;
    logic [7:0]      w_rval;
    logic            w_exec;
    logic            w_is_op3;
    logic            w_taken;
    logic            w_mov;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_next;

    assign w_op     = r_ir[7:6];
    assign w_a      = r_ir[5:2];
    assign w_r      = r_ir[1:0];
    assign w_exec   = (r_state == S_EXEC);
    assign w_is_op3 = (w_op == 2'd3);
    assign w_target = PC_W'(w_a);

    // Branch decision uses the flag registers before this instruction commits.
    assign w_taken   = (alu_bcf & r_carry) | (alu_bbf & r_borrow) | alu_buc;
    assign w_mov     = w_is_op3 & ~(alu_bcf | alu_bbf | alu_buc | alu_toggle);
    assign w_pc_next = (w_is_op3 && w_taken) ? w_target : (r_pc + PC_ONE);

    always_comb begin
        w_rval = data_in;
        unique case (w_r)
            2'd0:    w_rval = r_regs[0];
            2'd1:    w_rval = r_regs[1];
            2'd2:    w_rval = r_regs[2];
            default: w_rval = data_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        fetch_req    = 1'b0;
        retire       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                retire       = 1'b1;
                w_state_next = run ? S_FETCH : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        alu_opcode = 2'd0;
        alu_addrs  = 4'd0;
        alu_din0   = 8'd0;
        alu_din1   = 8'd0;
        if (w_exec) begin
            alu_opcode = w_op;
            alu_addrs  = w_a;
            alu_din0   = r_acc;
            alu_din1   = w_is_op3 ? 8'd0 : w_rval;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_ir <= 8'd0;
        end else begin
            if (r_state == S_FETCH && fetch_ack) begin
                r_ir <= fetch_data;
            end
            if (w_exec) begin
                r_pc <= w_pc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= 8'd0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_toggle <= 1'b0;
        end else if (w_exec) begin
            if (!w_is_op3) begin
                r_acc <= alu_dout;
            end
            if (w_op == 2'd0) begin
                r_carry <= alu_carry;
            end
            if (w_op == 2'd1) begin
                r_borrow <= alu_borrow;
            end
            if (w_is_op3 && alu_toggle) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

    // R0-R2 are internal; index 3 maps onto the external data_out register.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_regs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[gi] <= 8'd0;
                end else if (w_exec && w_mov && (w_r == 2'(gi))) begin
                    r_regs[gi] <= alu_dout;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= 8'd0;
        end else if (w_exec && w_mov && (w_r == 2'd3)) begin
            r_data_out <= alu_dout;
        end
    end

    assign fetch_addr  = r_pc;
    assign data_out    = r_data_out;
    assign acc_out     = r_acc;
    assign toggle_out  = r_toggle;
    assign carry_flag  = r_carry;
    assign borrow_flag = r_borrow;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: stand-in ALU and program memory, instruction-level reference model,
// and directed programs with hand-computed expectations.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       fetch_req;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       fetch_ack;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [1:0] alu_opcode;
    logic [3:0] alu_addrs;
    logic [7:0] alu_din0;
    logic [7:0] alu_din1;
    logic [7:0] alu_dout;
    logic       alu_carry;
    logic       alu_borrow;
    logic       alu_bcf;
    logic       alu_bbf;
    logic       alu_buc;
    logic       alu_toggle;
    logic [7:0] acc_out;
    logic       toggle_out;
    logic       carry_flag;
    logic       borrow_flag;
    logic       busy;
    logic       retire;

    int n_vec  = 0;
    int n_fail = 0;

    // Program memory and per-address ALU strobes {bcf, bbf, buc, toggle}.
    logic [7:0] prog [0:15];
    logic [3:0] strb [0:15];
    logic       ack_hold;
    logic       ack_drv;
    int         ack_delay;
    int         wait_cnt;
    int         ret_cyc [0:7];

    cpu_sequencer #(.PC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_ack(fetch_ack),
        .data_in(data_in), .data_out(data_out),
        .alu_opcode(alu_opcode), .alu_addrs(alu_addrs), .alu_din0(alu_din0), .alu_din1(alu_din1),
        .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_borrow(alu_borrow),
        .alu_bcf(alu_bcf), .alu_bbf(alu_bbf), .alu_buc(alu_buc), .alu_toggle(alu_toggle),
        .acc_out(acc_out), .toggle_out(toggle_out), .carry_flag(carry_flag), .borrow_flag(borrow_flag),
        .busy(busy), .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fetch_data = prog[fetch_addr];
    assign fetch_ack  = ack_hold | ack_drv;

    // Stand-in ALU: strobes come from the table, independent of opcode.
    logic [8:0] alu_sum;
    assign alu_sum    = {1'b0, alu_din0} + {1'b0, alu_din1};
    assign alu_carry  = (alu_opcode == 2'd0) && alu_sum[8];
    assign alu_borrow = (alu_opcode == 2'd1) && (alu_din0 < alu_din1);
    assign alu_bcf    = strb[fetch_addr][3];
    assign alu_bbf    = strb[fetch_addr][2];
    assign alu_buc    = strb[fetch_addr][1];
    assign alu_toggle = strb[fetch_addr][0];
    always_comb begin
        alu_dout = alu_din0;
        case (alu_opcode)
            2'd0:    alu_dout = alu_sum[7:0];
            2'd1:    alu_dout = alu_din0 - alu_din1;
            2'd2:    alu_dout = alu_din0 ^ alu_din1;
            default: alu_dout = alu_din0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch responder: ack after ack_delay wait cycles of a request.
    initial begin
        ack_drv  = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (fetch_req) begin
                ack_drv  = (wait_cnt >= ack_delay);
                wait_cnt = wait_cnt + 1;
            end else begin
                ack_drv  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Instruction-level reference model, compared every negedge.
    logic [3:0] m_pc;
    logic [7:0] m_acc, m_dout;
    logic [7:0] m_reg [0:2];
    logic       m_c, m_b, m_t;
    logic [7:0] t_ins, t_rv;
    logic [1:0] t_op, t_r;
    logic [3:0] t_a, t_s;
    logic [8:0] t_sum;
    logic       t_taken;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pc = 4'd0; m_acc = 8'd0; m_dout = 8'd0;
                m_c = 1'b0; m_b = 1'b0; m_t = 1'b0;
                for (int k = 0; k < 3; k++) m_reg[k] = 8'd0;
                chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_retire", {31'd0, retire}, 32'd0);
                chk("rst_state", {acc_out, data_out, 4'd0, fetch_addr, 4'd0,
                     toggle_out, carry_flag, borrow_flag, 1'b0}, 32'd0);
                chk("rst_alu", {10'd0, alu_opcode, alu_addrs, alu_din0, alu_din1}, 32'd0);
            end else begin
                chk("acc", {24'd0, acc_out}, {24'd0, m_acc});
                chk("flags", {29'd0, carry_flag, borrow_flag, toggle_out}, {29'd0, m_c, m_b, m_t});
                chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
                chk("pc", {28'd0, fetch_addr}, {28'd0, m_pc});
                if (!retire) begin
                    chk("alu_idle", {10'd0, alu_opcode, alu_addrs, alu_din0, alu_din1}, 32'd0);
                end else begin
                    t_ins = prog[m_pc];
                    t_op  = t_ins[7:6];
                    t_a   = t_ins[5:2];
                    t_r   = t_ins[1:0];
                    t_s   = strb[m_pc];
                    case (t_r)
                        2'd0:    t_rv = m_reg[0];
                        2'd1:    t_rv = m_reg[1];
                        2'd2:    t_rv = m_reg[2];
                        default: t_rv = data_in;
                    endcase
                    chk("alu_drive", {alu_opcode, alu_addrs, alu_din0, alu_din1},
                        {t_op, t_a, m_acc, (t_op == 2'd3) ? 8'd0 : t_rv});
                    case (t_op)
                        2'd0: begin
                            t_sum = {1'b0, m_acc} + {1'b0, t_rv};
                            m_acc = t_sum[7:0];
                            m_c   = t_sum[8];
                            m_pc  = m_pc + 4'd1;
                        end
                        2'd1: begin
                            m_b   = (m_acc < t_rv);
                            m_acc = m_acc - t_rv;
                            m_pc  = m_pc + 4'd1;
                        end
                        2'd2: begin
                            m_acc = m_acc ^ t_rv;
                            m_pc  = m_pc + 4'd1;
                        end
                        default: begin
                            t_taken = (t_s[3] & m_c) | (t_s[2] & m_b) | t_s[1];
                            m_pc    = t_taken ? t_a : m_pc + 4'd1;
                            if (t_s[0]) m_t = ~m_t;
                            if (t_s == 4'd0) begin
                                case (t_r)
                                    2'd0:    m_reg[0] = m_acc;
                                    2'd1:    m_reg[1] = m_acc;
                                    2'd2:    m_reg[2] = m_acc;
                                    default: m_dout   = m_acc;
                                endcase
                            end
                        end
                    endcase
                end
            end
        end
    end

    task automatic clear_prog();
        for (int k = 0; k < 16; k++) begin
            prog[k] = 8'h00;
            strb[k] = 4'h0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Run n instructions, dropping run during the n-th EXEC, then wait for IDLE.
    task automatic run_n(input int n);
        int cnt = 0;
        int cyc = 0;
        run = 1'b1;
        while (cnt < n && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (retire) begin
                if (cnt < 8) ret_cyc[cnt] = cyc;
                cnt++;
                if (cnt == n) run = 1'b0;
            end
        end
        run = 1'b0;
        chk("run_n_retires", cnt, n);
        while (busy && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("run_n_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        rst_n     = 1'b0;
        run       = 1'b1;
        ack_hold  = 1'b1;
        ack_delay = 0;
        data_in   = 8'h00;
        clear_prog();

        // 1: reset held with run and ack high, then release
        repeat (3) @(posedge clk);
        #1;
        chk("t1_req_in_reset", {31'd0, fetch_req}, 32'd0);
        chk("t1_busy_in_reset", {31'd0, busy}, 32'd0);
        ack_hold = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        chk("t1_req_after", {31'd0, fetch_req}, 32'd1);
        chk("t1_addr_after", {28'd0, fetch_addr}, 32'd0);
        run = 1'b0;
        for (int k = 0; k < 20 && busy; k++) begin
            @(posedge clk); #1;
        end
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // 2: ADD R3, MOV R0, ADD R0; strobes on the ADD must be ignored
        do_reset();
        clear_prog();
        prog[0] = 8'h03; strb[0] = 4'hF;
        prog[1] = 8'hC0;
        prog[2] = 8'h00;
        data_in = 8'h05;
        run_n(3);
        chk("t2_acc", {24'd0, acc_out}, 32'h0A);
        chk("t2_carry", {31'd0, carry_flag}, 32'd0);
        chk("t2_toggle", {31'd0, toggle_out}, 32'd0);
        chk("t2_pc", {28'd0, fetch_addr}, 32'd3);
        chk("t2_spacing01", ret_cyc[1] - ret_cyc[0], 32'd2);
        chk("t2_spacing12", ret_cyc[2] - ret_cyc[1], 32'd2);

        // 3: carry, bcf taken / not taken, MOV to R3
        do_reset();
        clear_prog();
        prog[0]  = 8'h03;
        prog[1]  = 8'h03;
        prog[2]  = 8'hE4; strb[2]  = 4'b1000;
        prog[9]  = 8'h03;
        prog[10] = 8'hE4; strb[10] = 4'b1000;
        prog[11] = 8'hC3;
        data_in = 8'hF0;
        run_n(1);
        chk("t3_acc_f0", {24'd0, acc_out}, 32'hF0);
        data_in = 8'h20;
        run_n(1);
        chk("t3_acc_10", {24'd0, acc_out}, 32'h10);
        chk("t3_carry1", {31'd0, carry_flag}, 32'd1);
        run_n(1);
        chk("t3_bcf_taken", {28'd0, fetch_addr}, 32'd9);
        data_in = 8'h00;
        run_n(1);
        chk("t3_carry0", {31'd0, carry_flag}, 32'd0);
        run_n(1);
        chk("t3_bcf_not_taken", {28'd0, fetch_addr}, 32'd11);
        run_n(1);
        chk("t3_data_out", {24'd0, data_out}, 32'h10);

        // 4: SUB borrow, toggle twice, no MOV on toggle, bbf branch
        do_reset();
        clear_prog();
        prog[0] = 8'h43;
        prog[1] = 8'hC0; strb[1] = 4'b0001;
        prog[2] = 8'hC0; strb[2] = 4'b0001;
        prog[3] = 8'h00;
        prog[4] = 8'hF0; strb[4] = 4'b0100;
        data_in = 8'h01;
        run_n(1);
        chk("t4_acc_ff", {24'd0, acc_out}, 32'hFF);
        chk("t4_borrow", {31'd0, borrow_flag}, 32'd1);
        run_n(1);
        chk("t4_toggle1", {31'd0, toggle_out}, 32'd1);
        chk("t4_pc2", {28'd0, fetch_addr}, 32'd2);
        run_n(1);
        chk("t4_toggle0", {31'd0, toggle_out}, 32'd0);
        chk("t4_pc3", {28'd0, fetch_addr}, 32'd3);
        run_n(1);
        chk("t4_r0_untouched", {23'd0, carry_flag, acc_out}, 32'h0FF);
        run_n(1);
        chk("t4_bbf_taken", {28'd0, fetch_addr}, 32'd12);

        // 5: ack delayed 3 cycles with run dropped during the wait
        do_reset();
        clear_prog();
        prog[0]   = 8'h03;
        data_in   = 8'h07;
        ack_delay = 3;
        run = 1'b1;
        @(posedge clk); #1;
        chk("t5_req", {31'd0, fetch_req}, 32'd1);
        run = 1'b0;
        fc = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (retire) break;
            chk("t5_req_held", {31'd0, fetch_req}, 32'd1);
            fc++;
        end
        chk("t5_fetch_cycles", fc, 32'd4);
        chk("t5_retire", {31'd0, retire}, 32'd1);
        @(posedge clk); #1;
        chk("t5_idle", {31'd0, busy}, 32'd0);
        chk("t5_pc", {28'd0, fetch_addr}, 32'd1);
        chk("t5_acc", {24'd0, acc_out}, 32'h07);
        ack_delay = 0;

        // 6: pc wrap 15 -> 0, then async reset in the middle of a fetch
        do_reset();
        clear_prog();
        prog[0]  = 8'hFC; strb[0] = 4'b0010;
        prog[15] = 8'h02;
        run_n(1);
        chk("t6_buc", {28'd0, fetch_addr}, 32'd15);
        run_n(1);
        chk("t6_wrap", {28'd0, fetch_addr}, 32'd0);
        run_n(1);
        chk("t6_pc15", {28'd0, fetch_addr}, 32'd15);
        ack_delay = 5;
        run = 1'b1;
        @(posedge clk); #1;
        chk("t6_req_before", {31'd0, fetch_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        chk("t6_req_async", {31'd0, fetch_req}, 32'd0);
        chk("t6_pc_async", {28'd0, fetch_addr}, 32'd0);
        chk("t6_busy_async", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_delay = 0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
